// File: rtl/output_deskew_buffer.sv
// output_deskew_buffer
// Re-aligns the skewed per-column results leaving the systolic array into
// whole rows. Each column has its own FIFO; a row is emitted only when every
// column holds at least one entry, and all columns are popped together.
module output_deskew_buffer #(
    parameter int SYS_COLS     = 4,
    parameter int ACC_BITWIDTH = 32,
    parameter int DEPTH        = 8,
    parameter int OUT_ROWS     = 4
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [SYS_COLS-1:0]              i_valid,
    input  logic [SYS_COLS*ACC_BITWIDTH-1:0] i_data,
    output logic                             o_valid,
    input  logic                             o_ready,
    output logic [SYS_COLS*ACC_BITWIDTH-1:0] o_data,
    output logic                             o_last,
    output logic                             o_done,
    output logic [SYS_COLS-1:0]              overflow
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int RW = (OUT_ROWS > 1) ? $clog2(OUT_ROWS) : 1;
    localparam logic [PW:0]   FULL     = (PW+1)'(DEPTH);
    localparam logic [PW-1:0] PTR_MAX  = PW'(DEPTH - 1);
    localparam logic [RW-1:0] LAST_ROW = RW'(OUT_ROWS - 1);

    logic [ACC_BITWIDTH-1:0] mem    [SYS_COLS][DEPTH];
    logic [PW-1:0]           wr_ptr [SYS_COLS];
    logic [PW-1:0]           rd_ptr [SYS_COLS];
    logic [PW:0]             count  [SYS_COLS];
    logic [RW-1:0]           row_cnt;
    logic [SYS_COLS-1:0]     push;
    logic                    pop;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PTR_MAX) ? '0 : p + 1'b1;
    endfunction

    // Row availability, head-of-FIFO data and per-column push decisions
    always_comb begin
        o_valid = 1'b1;
        o_data  = '0;
        for (int unsigned c = 0; c < SYS_COLS; c++) begin
            if (count[c] == '0) o_valid = 1'b0;
            o_data[c*ACC_BITWIDTH +: ACC_BITWIDTH] = mem[c][rd_ptr[c]];
        end
        pop    = o_valid && o_ready;
        o_last = o_valid && (row_cnt == LAST_ROW);
        push   = '0;
        for (int unsigned c = 0; c < SYS_COLS; c++) begin
            // A same-edge pop frees a slot, so a full FIFO still takes the write
            push[c] = i_valid[c] && ((count[c] < FULL) || pop);
        end
    end

    // FIFO storage writes; contents are intentionally left unreset
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int unsigned c = 0; c < SYS_COLS; c++) begin
                if (push[c]) mem[c][wr_ptr[c]] <= i_data[c*ACC_BITWIDTH +: ACC_BITWIDTH];
            end
        end
    end

    // Pointers, occupancy, sticky overflow, row counter and done pulse
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned c = 0; c < SYS_COLS; c++) begin
                wr_ptr[c] <= '0;
                rd_ptr[c] <= '0;
                count[c]  <= '0;
            end
            row_cnt  <= '0;
            o_done   <= 1'b0;
            overflow <= '0;
        end else begin
            for (int unsigned c = 0; c < SYS_COLS; c++) begin
                if (push[c]) wr_ptr[c] <= ptr_inc(wr_ptr[c]);
                if (pop)     rd_ptr[c] <= ptr_inc(rd_ptr[c]);
                if (push[c] && !pop)      count[c] <= count[c] + 1'b1;
                else if (!push[c] && pop) count[c] <= count[c] - 1'b1;
                if (i_valid[c] && !push[c]) overflow[c] <= 1'b1;
            end
            o_done <= pop && o_last;
            if (pop) row_cnt <= o_last ? '0 : row_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_output_deskew_buffer.sv
// Self-checking bench for output_deskew_buffer: directed scenarios with
// random data plus a fully random phase, all compared against a queue model.
module tb_output_deskew_buffer;

    localparam int SYS_COLS = 4;
    localparam int ACC      = 32;
    localparam int DEPTH    = 8;
    localparam int OUT_ROWS = 4;
    localparam int W        = SYS_COLS * ACC;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                rst;
    logic [SYS_COLS-1:0] i_valid;
    logic [W-1:0]        i_data;
    logic                o_valid;
    logic                o_ready;
    logic [W-1:0]        o_data;
    logic                o_last;
    logic                o_done;
    logic [SYS_COLS-1:0] overflow;

    output_deskew_buffer #(
        .SYS_COLS(SYS_COLS), .ACC_BITWIDTH(ACC), .DEPTH(DEPTH), .OUT_ROWS(OUT_ROWS)
    ) dut (
        .clk(clk), .rst(rst), .i_valid(i_valid), .i_data(i_data),
        .o_valid(o_valid), .o_ready(o_ready), .o_data(o_data),
        .o_last(o_last), .o_done(o_done), .overflow(overflow)
    );

    // Second instance: single-row tiles
    logic                rst1;
    logic [SYS_COLS-1:0] iv1;
    logic [W-1:0]        id1;
    logic                ov1;
    logic                rdy1;
    logic [W-1:0]        od1;
    logic                ol1;
    logic                odn1;
    logic [SYS_COLS-1:0] ovf1;

    output_deskew_buffer #(
        .SYS_COLS(SYS_COLS), .ACC_BITWIDTH(ACC), .DEPTH(DEPTH), .OUT_ROWS(1)
    ) dut1 (
        .clk(clk), .rst(rst1), .i_valid(iv1), .i_data(id1),
        .o_valid(ov1), .o_ready(rdy1), .o_data(od1),
        .o_last(ol1), .o_done(odn1), .overflow(ovf1)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference model: one queue per column, row index within tile
    logic [ACC-1:0]      mq [SYS_COLS][$];
    int                  m_row  = 0;
    logic                m_done = 1'b0;
    logic [SYS_COLS-1:0] m_ovf  = '0;

    function automatic bit model_valid();
        for (int c = 0; c < SYS_COLS; c++) if (mq[c].size() == 0) return 1'b0;
        return 1'b1;
    endfunction

    task automatic model_update();
        bit popv;
        if (rst) begin
            for (int c = 0; c < SYS_COLS; c++) mq[c].delete();
            m_row  = 0;
            m_done = 1'b0;
            m_ovf  = '0;
            return;
        end
        popv   = model_valid() && o_ready;
        m_done = popv && (m_row == OUT_ROWS - 1);
        if (popv) begin
            for (int c = 0; c < SYS_COLS; c++) void'(mq[c].pop_front());
            m_row = (m_row + 1) % OUT_ROWS;
        end
        for (int c = 0; c < SYS_COLS; c++) begin
            if (i_valid[c]) begin
                if (mq[c].size() < DEPTH) mq[c].push_back(i_data[c*ACC +: ACC]);
                else m_ovf[c] = 1'b1;
            end
        end
    endtask

    // Compare current outputs with the model, then advance one clock
    task automatic tick();
        bit           ev;
        logic [W-1:0] ed;
        ev = model_valid();
        ed = '0;
        check("o_valid", W'(o_valid), W'(ev));
        check("o_last", W'(o_last), W'(ev && (m_row == OUT_ROWS - 1)));
        check("o_done", W'(o_done), W'(m_done));
        check("overflow", W'(overflow), W'(m_ovf));
        if (ev) begin
            for (int c = 0; c < SYS_COLS; c++) ed[c*ACC +: ACC] = mq[c][0];
            check("o_data", o_data, ed);
        end
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    // Perfectly skewed rows: column c gets row r at step r+c
    task automatic run_skew(input int nrows, input int ready_at, input bit rnd, input bit chk_first);
        int first = -1;
        int total;
        int r;
        total = ((nrows + SYS_COLS) > ready_at ? nrows + SYS_COLS : ready_at) + nrows + 3;
        for (int t = 0; t < total; t++) begin
            i_valid = '0;
            for (int c = 0; c < SYS_COLS; c++) begin
                r = t - c;
                if (r >= 0 && r < nrows) begin
                    i_valid[c] = 1'b1;
                    i_data[c*ACC +: ACC] = rnd ? ACC'($urandom) : ACC'(100 * r + c);
                end
            end
            o_ready = (t >= ready_at);
            if (first < 0 && o_valid) first = t;
            tick();
        end
        i_valid = '0;
        if (chk_first) check("first_valid", W'(first), W'(SYS_COLS));
    endtask

    task automatic fill_all(input int n, input logic [SYS_COLS-1:0] mask, input logic rdy);
        for (int k = 0; k < n; k++) begin
            i_valid = mask;
            for (int c = 0; c < SYS_COLS; c++) i_data[c*ACC +: ACC] = ACC'($urandom);
            o_ready = rdy;
            tick();
        end
        i_valid = '0;
    endtask

    task automatic drain(input int n);
        i_valid = '0;
        o_ready = 1'b1;
        for (int k = 0; k < n; k++) tick();
    endtask

    initial begin
        bit   prev_pop;
        int   k_in;
        int   k_out;
        logic [W-1:0] ed;

        rst = 1'b1; i_valid = '0; i_data = '0; o_ready = 1'b0;
        rst1 = 1'b1; iv1 = '0; id1 = '0; rdy1 = 1'b0;
        repeat (3) @(posedge clk);
        model_update();
        #1;
        rst = 1'b0;

        // Skewed fill, ready always high, values 100*r+c
        run_skew(4, 0, 1'b0, 1'b1);

        // Back-pressure until step 10
        run_skew(4, 10, 1'b0, 1'b1);

        // Overflow on column 0
        o_ready = 1'b0;
        fill_all(9, 4'b0001, 1'b0);
        fill_all(1, 4'b1110, 1'b0);
        drain(3);
        check("ovf_sticky", W'(overflow), W'(4'b0001));
        do_reset();

        // All FIFOs full, then simultaneous push and pop
        fill_all(8, 4'b1111, 1'b0);
        fill_all(1, 4'b1111, 1'b1);
        drain(10);
        do_reset();

        // Reset mid-tile: 2 rows accepted, 3 still buffered
        fill_all(5, 4'b1111, 1'b0);
        drain(2);
        o_ready = 1'b0;
        do_reset();
        check("rst_o_valid", W'(o_valid), '0);
        check("rst_o_done", W'(o_done), '0);
        run_skew(4, 0, 1'b1, 1'b0);

        // Random traffic with occasional resets
        for (int t = 0; t < 400; t++) begin
            rst = ($urandom_range(0, 63) == 0);
            for (int c = 0; c < SYS_COLS; c++) begin
                i_valid[c] = ($urandom_range(0, 3) != 0);
                i_data[c*ACC +: ACC] = ACC'($urandom);
            end
            o_ready = ($urandom_range(0, 7) != 0);
            tick();
        end
        rst = 1'b0;
        drain(DEPTH + 2);

        // OUT_ROWS=1 instance: continuous skewed stream, ready held high
        rst1 = 1'b0;
        rdy1 = 1'b1;
        prev_pop = 1'b0;
        k_out = 0;
        for (int t = 0; t < 6 + SYS_COLS + 2; t++) begin
            iv1 = '0;
            for (int c = 0; c < SYS_COLS; c++) begin
                k_in = t - c;
                if (k_in >= 0 && k_in < 6) begin
                    iv1[c] = 1'b1;
                    id1[c*ACC +: ACC] = ACC'(1000 * k_in + c);
                end
            end
            check("r1_o_last", W'(ol1), W'(ov1));
            check("r1_o_done", W'(odn1), W'(prev_pop));
            if (ov1) begin
                for (int c = 0; c < SYS_COLS; c++) ed[c*ACC +: ACC] = ACC'(1000 * k_out + c);
                check("r1_o_data", od1, ed);
                k_out++;
            end
            prev_pop = ov1 && rdy1;
            @(posedge clk);
            #1;
        end
        iv1 = '0;
        check("r1_rows", W'(k_out), W'(6));
        check("r1_ovf", W'(ovf1), '0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
